muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit that owns the HI/LO register pair.
- Successor to the fixed 32-bit MULT/MULTU/DIV/DIVU instances and discrete HI/LO registers in the single-cycle core.
- Adds a unified start/busy/done handshake, a cancel path for exceptions, defined divide-by-zero and overflow results, and a width parameter.
- The core stalls its PC while busy is high, and reads HI/LO through hi_out/lo_out.

Parameters:
- WIDTH, 32, operand/HI/LO width in bits (even, >=4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (low = reset).
- start  input  1  request; sampled only when busy=0.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored.
- a  input  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data).
- b  input  WIDTH  rt operand (divisor / multiplier).
- cancel  input  1  abort in-flight op (exception/eret).
- busy  output  1  iterative op in flight.
- done  output  1  one-cycle pulse: HI/LO just updated by an iterative op.
- div_zero  output  1  valid with done: last op was DIV/DIVU with b==0.
- hi_out  output  WIDTH  HI register.
- lo_out  output  WIDTH  LO register.

Behaviour:
- Reset (rst low, async): state=IDLE; busy=0, done=0, div_zero=0, hi_out=0, lo_out=0, counter=0.
- FSM states:
  - IDLE: on start & op in {000..011}, latch operands and op. For signed ops, latch magnitudes plus result sign bits. Load counter=WIDTH, go to RUN.
  - RUN: one radix-2 step per cycle (shift-add multiply; restoring divide), counter decrements. At counter==1, go to FIX.
  - FIX: apply sign correction, write HI/LO, go to IDLE. done=1 and div_zero are registered, so both are visible in the following IDLE cycle.
- Latency:
  - start accepted at edge k; busy=1 from edge k+1 through WIDTH+1 cycles (RUN=WIDTH, FIX=1).
  - At edge k+WIDTH+2: busy=0, done=1, and HI/LO hold the new values.
  - done lasts exactly one cycle.
- MTHI/MTLO (start & op 100/101, busy=0): HI or LO takes a at the next edge. No busy, no done; the other register is unchanged.
- start while busy=1: ignored, no queuing. op 110/111: ignored.
- Multiply: {HI,LO} = full 2*WIDTH-bit product, signed for MULT, unsigned for MULTU.
- Divide: LO=quotient, HI=remainder.
  - Truncation toward zero; remainder takes the dividend's sign.
  - Divisor 0: LO=all ones, HI=a, div_zero=1 with done. Full iteration latency is still taken.
  - DIV of most-negative by -1: LO=most-negative, HI=0, div_zero=0.
- cancel:
  - When busy=1: at the next edge go to IDLE, busy=0, HI/LO unchanged, no done.
  - cancel has priority over FIX completion in the same cycle.
  - cancel in IDLE has no effect, and also blocks a simultaneous start.
- Simultaneous start and done cycle: the new op is accepted, because busy is already 0 in the done cycle.
- Reset mid-operation: immediate abort to the reset values above.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined: MULT/MULTU use a single-cycle array product. start at edge k: busy stays 0, HI/LO updated and done=1 at edge k+1. DIV timing is unchanged.
- Undefined: multiply is iterative with the same WIDTH+1-cycle busy as divide.

Test Plan:
- MULT a=FFFFFFFD (-3), b=00000005 -> busy exactly 33 cycles; then done=1, HI=FFFFFFFF, LO=FFFFFFF1.
- DIVU a=100, b=7 -> LO=14, HI=2, div_zero=0. DIV a=-7, b=2 -> LO=FFFFFFFD, HI=FFFFFFFF. DIV a=80000000, b=FFFFFFFF -> LO=80000000, HI=0.
- DIVU a=1234, b=0 -> after 33 busy cycles: done=1, div_zero=1, LO=FFFFFFFF, HI=1234.
- Pre-set HI=AAAA0000, LO=5555 via MTHI/MTLO; start MULTU, assert cancel on busy cycle 10 -> next cycle busy=0, no done, HI=AAAA0000, LO=5555. Then a start with op=MTLO during busy is ignored.
- Pull rst low mid-DIV -> busy, done, HI, LO all 0 asynchronously. Release, then MULTU FFFFFFFF*FFFFFFFF -> HI=FFFFFFFE, LO=00000001.
- WIDTH=8, MULTU 0xFF*0xFF -> busy 9 cycles, HI=FE, LO=01. With MULDIV_FAST_MUL_EN: same result, done at edge k+1, busy never high.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit that owns the HI/LO register pair.
// Optional macro MULDIV_FAST_MUL_EN selects a single-cycle array multiplier; divide stays iterative.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   // Handshake: start is sampled only while busy is low (and cancel is low).
   // An accepted iterative op raises busy from the next edge; when it falls,
   // done pulses for exactly that one cycle with HI/LO already updated, and a
   // new start may be presented in that same done cycle. cancel drops busy at
   // the next edge without done and leaves HI/LO untouched.

   localparam int W2 = 2 * WIDTH;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic             idle;
   logic             go;
   logic             is_mul_op;
   logic             is_div_op;
   logic             signed_op;
   logic             iter_accept;
   logic             fix_commit;

   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

   logic [CNT_W-1:0] cnt;
   logic             is_div;
   logic             neg_q;
   logic             neg_r;
   logic             dz_q;
   logic [WIDTH-1:0] opnd;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] shf;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic             div_ok;
   logic [WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0] shf_nxt;

   logic [W2-1:0]    prod_mag;
   logic [W2-1:0]    prod_res;
   logic [WIDTH-1:0] quo_res;
   logic [WIDTH-1:0] rem_res;

   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic             done_q;
   logic             dz_out_q;

   assign idle      = (state == S_IDLE);
   assign go        = idle & start & ~cancel;
   assign is_mul_op = (op == OP_MULT) | (op == OP_MULTU);
   assign is_div_op = (op == OP_DIV) | (op == OP_DIVU);
   assign signed_op = (op == OP_MULT) | (op == OP_DIV);

   // Signed ops run on magnitudes; the signs are reapplied in FIX.
   assign a_neg = signed_op & a[WIDTH-1];
   assign b_neg = signed_op & b[WIDTH-1];
   assign a_mag = a_neg ? -a : a;
   assign b_mag = b_neg ? -b : b;

`ifdef MULDIV_FAST_MUL_EN
   logic          fast_accept;
   logic [W2-1:0] fast_mag;
   logic [W2-1:0] fast_res;

   assign fast_accept = go & is_mul_op;
   assign iter_accept = go & is_div_op;
   assign fast_mag    = W2'(a_mag) * W2'(b_mag);
   assign fast_res    = (a_neg ^ b_neg) ? -fast_mag : fast_mag;
`else
   assign iter_accept = go & (is_mul_op | is_div_op);
`endif

   assign fix_commit = (state == S_FIX) & ~cancel;

   // Next-state logic; cancel wins over every transition out of RUN/FIX.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (iter_accept) state_nxt = S_RUN;
         S_RUN: begin
            if (cancel)                    state_nxt = S_IDLE;
            else if (cnt == CNT_W'(1))     state_nxt = S_FIX;
         end
         S_FIX:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // One radix-2 step. Multiply: {acc,shf} shifts right as the multiplier
   // bits in shf are consumed. Divide: restoring step, quotient bits enter shf.
   assign mul_sum   = {1'b0, acc} + (shf[0] ? {1'b0, opnd} : '0);
   assign div_shift = {acc, shf[WIDTH-1]};
   assign div_ok    = (div_shift >= {1'b0, opnd});

   always_comb begin
      acc_nxt = mul_sum[WIDTH:1];
      shf_nxt = {mul_sum[0], shf[WIDTH-1:1]};
      if (is_div) begin
         acc_nxt = div_ok ? (div_shift[WIDTH-1:0] - opnd) : div_shift[WIDTH-1:0];
         shf_nxt = {shf[WIDTH-2:0], div_ok};
      end
   end

   // A zero divisor still iterates: every trial succeeds, so the remainder
   // ends as |a| and the sign fix-up restores a; only LO needs forcing.
   assign prod_mag = {acc, shf};
   assign prod_res = neg_q ? -prod_mag : prod_mag;
   assign quo_res  = dz_q ? '1 : (neg_q ? -shf : shf);
   assign rem_res  = neg_r ? -acc : acc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= '0;
         is_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         dz_q     <= 1'b0;
         opnd     <= '0;
         acc      <= '0;
         shf      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         dz_out_q <= 1'b0;
      end else begin
         done_q   <= 1'b0;
         dz_out_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (iter_accept) begin
                  cnt    <= CNT_W'(WIDTH);
                  is_div <= is_div_op;
                  neg_q  <= a_neg ^ b_neg;
                  neg_r  <= a_neg;
                  dz_q   <= is_div_op & (b == '0);
                  acc    <= '0;
                  if (is_div_op) begin
                     opnd <= b_mag;
                     shf  <= a_mag;
                  end else begin
                     opnd <= a_mag;
                     shf  <= b_mag;
                  end
               end
               if (go && op == OP_MTHI) hi_q <= a;
               if (go && op == OP_MTLO) lo_q <= a;
`ifdef MULDIV_FAST_MUL_EN
               if (fast_accept) begin
                  hi_q   <= fast_res[W2-1:WIDTH];
                  lo_q   <= fast_res[WIDTH-1:0];
                  done_q <= 1'b1;
               end
`endif
            end
            S_RUN: begin
               acc <= acc_nxt;
               shf <= shf_nxt;
               cnt <= cnt - CNT_W'(1);
            end
            S_FIX: begin
               if (fix_commit) begin
                  if (is_div) begin
                     hi_q <= rem_res;
                     lo_q <= quo_res;
                  end else begin
                     hi_q <= prod_res[W2-1:WIDTH];
                     lo_q <= prod_res[WIDTH-1:0];
                  end
                  done_q   <= 1'b1;
                  dz_out_q <= is_div & dz_q;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy     = ~idle;
   assign done     = done_q;
   assign div_zero = dz_out_q;
   assign hi_out   = hi_q;
   assign lo_out   = lo_q;

endmodule
